pipe_stall_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It compares the D-stage source registers and their Tuse against the Tnew/A3 of the instructions in E and M, then drives the enables and clears of the PC, F/D, D/E and E/M pipeline registers. It also sequences the multi-cycle multiply/divide unit with a busy counter, and stalls any D-stage HI/LO or mult/div instruction until that unit is free.

---
 rtl/pipe_stall_ctrl.sv | 97 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline.
// Also sequences the multi-cycle multiply/divide unit.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs,
  input  logic [1:0] Tuse_rt,
  input  logic [4:0] A3_E,
  input  logic [4:0] A3_M,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic [1:0] Tnew_E,
  input  logic [1:0] Tnew_M,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       md_use_D,
  output logic       en_PC,
  output logic       en_FD,
  output logic       clr_DE,
  output logic       en_EM,
  output logic       md_busy,
  output logic       md_done
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_t;

  md_state_t  state_q;
  md_state_t  state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic hz_rs;
  logic hz_rt;
  logic hz_md;
  logic stall;

  // Tnew == 0 is covered by forwarding, so a strict compare suffices
  assign hz_rs = (A1_D != 5'd0) && (
    (RegWrite_E && (A3_E == A1_D) && (Tnew_E > Tuse_rs)) ||
    (RegWrite_M && (A3_M == A1_D) && (Tnew_M > Tuse_rs)));

  assign hz_rt = (A2_D != 5'd0) && (
    (RegWrite_E && (A3_E == A2_D) && (Tnew_E > Tuse_rt)) ||
    (RegWrite_M && (A3_M == A2_D) && (Tnew_M > Tuse_rt)));

  assign hz_md = md_use_D && (md_start || md_busy);

  assign stall  = hz_rs || hz_rt || hz_md;
  assign en_PC  = ~stall;
  assign en_FD  = ~stall;
  assign clr_DE = stall;
  assign en_EM  = 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          cnt_d   = md_is_div ? DIV_N : MULT_N;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // a start arriving here is ignored; the MD hazard prevents it
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_busy <= (cnt_d != 4'd0);
      md_done <= (cnt_d == 4'd1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized bench for pipe_stall_ctrl against a timestamp model,
// plus directed cases with hand-computed expectations.
module tb_pipe_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] A1_D, A2_D, A3_E, A3_M;
  logic [1:0] Tuse_rs, Tuse_rt, Tnew_E, Tnew_M;
  logic       RegWrite_E, RegWrite_M;
  logic       md_start, md_is_div, md_use_D;
  logic       en_PC, en_FD, clr_DE, en_EM, md_busy, md_done;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .A1_D(A1_D), .A2_D(A2_D),
    .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
    .A3_E(A3_E), .A3_M(A3_M),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .md_start(md_start), .md_is_div(md_is_div),
    .md_use_D(md_use_D),
    .en_PC(en_PC), .en_FD(en_FD), .clr_DE(clr_DE),
    .en_EM(en_EM), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remember the edge index of the last accepted start and
  // its length; busy/done follow from elapsed edges.
  int  edge_no = 0;
  int  st_edge = 0;
  int  st_len  = 0;
  bit  st_have = 0;
  int  elapsed;
  bit  m_busy, m_done;

  always_comb begin
    elapsed = edge_no - 1 - st_edge;
    m_busy  = st_have && (elapsed < st_len);
    m_done  = st_have && (elapsed == st_len - 1);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_no <= 0;
      st_have <= 0;
    end else begin
      edge_no <= edge_no + 1;
      if (md_start && !m_busy) begin
        st_edge <= edge_no;
        st_len  <= md_is_div ? DIV_N : MULT_N;
        st_have <= 1;
      end
    end
  end

  function automatic bit src_waits(int a, int tuse);
    int dst[2];
    int tn[2];
    bit we[2];
    dst = '{int'(A3_E), int'(A3_M)};
    tn  = '{int'(Tnew_E), int'(Tnew_M)};
    we  = '{RegWrite_E, RegWrite_M};
    if (a == 0) return 0;
    for (int p = 0; p < 2; p++)
      if (we[p] && dst[p] == a && tn[p] > tuse) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit s;
    s = src_waits(A1_D, Tuse_rs) || src_waits(A2_D, Tuse_rt) ||
        (md_use_D && (md_start || m_busy));
    chk("en_PC", en_PC, !s);
    chk("en_FD", en_FD, !s);
    chk("clr_DE", clr_DE, s);
    chk("en_EM", en_EM, 1);
    chk("md_busy", md_busy, m_busy);
    chk("md_done", md_done, m_done);
  end

  task automatic quiet();
    A1_D = 0; A2_D = 0; A3_E = 0; A3_M = 0;
    Tuse_rs = 3; Tuse_rt = 3; Tnew_E = 0; Tnew_M = 0;
    RegWrite_E = 0; RegWrite_M = 0;
    md_start = 0; md_is_div = 0; md_use_D = 0;
  endtask

  task automatic md_run(input bit div, input int n);
    @(posedge clk); #1;
    quiet();
    md_start = 1; md_is_div = div; md_use_D = 1;
    @(negedge clk); #1;
    chk("md_issue_stall", en_PC, 0);
    chk("md_issue_busy", md_busy, 0);
    @(posedge clk); #1;
    md_start = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("md_seq_busy", md_busy, 1);
      chk("md_seq_done", md_done, (i == n - 1) ? 1 : 0);
      chk("md_seq_clr", clr_DE, 1);
    end
    @(negedge clk); #1;
    chk("md_end_busy", md_busy, 0);
    chk("md_end_done", md_done, 0);
    chk("md_end_enPC", en_PC, 1);
    md_use_D = 0;
  endtask

  initial begin
    int scnt;
    int emfail;
    quiet();
    reset = 0;
    #12;
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_enPC", en_PC, 1);
    chk("rst_clrDE", clr_DE, 0);
    chk("rst_enEM", en_EM, 1);
    @(posedge clk); #1;
    reset = 1;

    // load-use
    @(posedge clk); #1;
    A3_E = 8; RegWrite_E = 1; Tnew_E = 2; A1_D = 8; Tuse_rs = 1;
    @(negedge clk); #1;
    chk("lu_enPC", en_PC, 0);
    chk("lu_enFD", en_FD, 0);
    chk("lu_clrDE", clr_DE, 1);
    @(posedge clk); #1;
    A3_E = 0; RegWrite_E = 0; Tnew_E = 0;
    A3_M = 8; RegWrite_M = 1; Tnew_M = 1;
    @(negedge clk); #1;
    chk("lu_adv_enPC", en_PC, 1);

    // zero register
    @(posedge clk); #1;
    quiet();
    A3_E = 0; RegWrite_E = 1; Tnew_E = 2; A1_D = 0; Tuse_rs = 1;
    @(negedge clk); #1;
    chk("zero_clrDE", clr_DE, 0);

    md_run(0, MULT_N);
    md_run(1, DIV_N);

    // reset in the middle of a divide
    @(posedge clk); #1;
    quiet();
    md_start = 1; md_is_div = 1;
    @(posedge clk); #1;
    md_start = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_pre_busy", md_busy, 1);
    reset = 0;
    #1;
    chk("mid_rst_busy", md_busy, 0);
    chk("mid_rst_done", md_done, 0);
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      chk("post_rst_busy", md_busy, 0);
    end

    // combined register and MD hazard
    @(posedge clk); #1;
    quiet();
    md_start = 1; md_use_D = 1;
    A1_D = 5; A3_E = 5; RegWrite_E = 1; Tnew_E = 2; Tuse_rs = 0;
    scnt = 0;
    emfail = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (clr_DE) scnt++;
      if (!en_EM) emfail++;
      @(posedge clk); #1;
      md_start = 0;
      if (i == 1) begin
        A3_E = 0; RegWrite_E = 0; Tnew_E = 0;
      end
    end
    chk("comb_stall_len", scnt, 1 + MULT_N);
    chk("comb_enEM", emfail, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      A1_D = 5'($urandom_range(0, 3));
      A2_D = 5'($urandom_range(0, 3));
      A3_E = 5'($urandom_range(0, 3));
      A3_M = 5'($urandom_range(0, 3));
      Tuse_rs = 2'($urandom_range(0, 3));
      Tuse_rt = 2'($urandom_range(0, 3));
      Tnew_E = 2'($urandom_range(0, 3));
      Tnew_M = 2'($urandom_range(0, 3));
      RegWrite_E = 1'($urandom_range(0, 1));
      RegWrite_M = 1'($urandom_range(0, 1));
      md_start = ($urandom_range(0, 7) == 0);
      md_is_div = 1'($urandom_range(0, 1));
      md_use_D = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        reset = 0;
        #2;
        reset = 1;
      end
    end

    @(posedge clk); #1;
    quiet();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
